// File: rtl/multicycle_control_unit_if.sv
// Unified memory port between the multicycle controller (master) and memory (slave).
// Handshake: mem_req is held with a stable mem_we/i_or_d until a cycle where mem_ready=1 completes it.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback,
// traps on illegal opcodes and memory timeouts, and counts retired instructions.
module multicycle_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  multicycle_control_unit_if.master bus,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [3:0]           state_o,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [3:0] RESET_S  = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] MEM_ADDR = 4'd3;
  localparam logic [3:0] MEM_RD   = 4'd4;
  localparam logic [3:0] MEM_WB   = 4'd5;
  localparam logic [3:0] MEM_WR   = 4'd6;
  localparam logic [3:0] EXEC_R   = 4'd7;
  localparam logic [3:0] EXEC_I   = 4'd8;
  localparam logic [3:0] ALU_WB   = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;
  localparam logic [3:0] JAL      = 4'd11;
  localparam logic [3:0] TRAP     = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]        state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_stall, timeout_hit, retire;
  logic              set_illegal, set_bus_err;

  assign wait_stall = bus.mem_req & ~bus.mem_ready;
  // The limit is judged on the cycle that would make the count reach TIMEOUT,
  // so a late mem_ready on that same cycle still completes normally.
  assign timeout_hit = (TIMEOUT > 0) && wait_stall && ((int'(wait_cnt) + 1) >= TIMEOUT);
  assign retire = (state == ALU_WB) || (state == MEM_WB) || (state == BRANCH) ||
                  ((state == MEM_WR) && bus.mem_ready);
  assign state_o = state;

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state)
      RESET_S:  state_next = FETCH;
      FETCH:    if (bus.mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              state_next = EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_LOAD, OP_STORE: state_next = MEM_ADDR;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          default: begin
            state_next  = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (bus.mem_ready) state_next = MEM_WB;
      MEM_WB:   state_next = FETCH;
      MEM_WR:   if (bus.mem_ready) state_next = FETCH;
      EXEC_R:   state_next = ALU_WB;
      EXEC_I:   state_next = ALU_WB;
      ALU_WB:   state_next = FETCH;
      BRANCH:   state_next = FETCH;
      JAL:      state_next = ALU_WB;
      TRAP:     state_next = TRAP;
      default: begin
        state_next  = TRAP;
        set_bus_err = 1'b1;
      end
    endcase
    if (timeout_hit) begin
      state_next  = TRAP;
      set_bus_err = 1'b1;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.i_or_d  = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      ALU_WB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
      end
      JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_S;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= ((state_next != state) || !wait_stall) ? '0 : wait_cnt + 1'b1;
      if (retire)      retired <= retired + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle expected state and
// control word is queued from an instruction-level model, then compared cycle by cycle.
module tb_multicycle_control_unit;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MADDR = 4'd3,
                         S_MRD   = 4'd4,  S_MWB   = 4'd5,  S_MWR    = 4'd6, S_EXR   = 4'd7,
                         S_EXI   = 4'd8,  S_AWB   = 4'd9,  S_BR     = 4'd10, S_JAL  = 4'd11,
                         S_TRAP  = 4'd15;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        ir_write, pc_write, pc_write_cond, reg_write, illegal, bus_err;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0]  state_o;
  logic [31:0] retired;

  multicycle_control_unit_if mcu_bus ();

  multicycle_control_unit #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .bus(mcu_bus),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [18:0] exp_q[$];
  logic        ready_q[$];
  int          exp_retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write, a, b, op, result_src}
  function automatic logic [14:0] ctrl_of(input logic [3:0] s, input logic r);
    case (s)
      S_FETCH:  return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      S_DECODE: return {7'b0, 2'b01, 2'b01, 2'b00, 2'b00};
      S_MADDR:  return {7'b0, 2'b10, 2'b01, 2'b00, 2'b00};
      S_MRD:    return {7'b1010000, 8'b0};
      S_MWB:    return {7'b0000001, 6'b0, 2'b01};
      S_MWR:    return {7'b1110000, 8'b0};
      S_EXR:    return {7'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      S_EXI:    return {7'b0, 2'b10, 2'b01, 2'b11, 2'b00};
      S_AWB:    return {7'b0000001, 8'b0};
      S_BR:     return {7'b0000010, 2'b10, 2'b00, 2'b01, 2'b00};
      S_JAL:    return {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b00};
      default:  return 15'b0;
    endcase
  endfunction

  function automatic logic [14:0] ctrl_obs();
    return {mcu_bus.mem_req, mcu_bus.mem_we, mcu_bus.i_or_d, ir_write, pc_write, pc_write_cond,
            reg_write, alu_src_a, alu_src_b, alu_op, result_src};
  endfunction

  // driver tasks
  task automatic push_step(input logic [3:0] s, input logic r);
    exp_q.push_back({s, ctrl_of(s, r)});
    ready_q.push_back(r);
  endtask

  task automatic push_any(input logic [3:0] s);
    push_step(s, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input bit check_ret);
    logic [18:0] e;
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      mcu_bus.mem_ready = ready_q.pop_front();
      #1;
      check("state", 32'(state_o), 32'(e[18:15]));
      check("ctrl", 32'(ctrl_obs()), 32'(e[14:0]));
      if (first && check_ret) check("retired", retired, 32'(exp_retired));
      first = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    opcode = op;
    for (int i = 0; i < fw; i++) push_step(S_FETCH, 1'b0);
    push_step(S_FETCH, 1'b1);
    push_any(S_DECODE);
    case (op)
      OP_R:   begin push_any(S_EXR); push_any(S_AWB); end
      OP_I:   begin push_any(S_EXI); push_any(S_AWB); end
      OP_LW: begin
        push_any(S_MADDR);
        for (int i = 0; i < mw; i++) push_step(S_MRD, 1'b0);
        push_step(S_MRD, 1'b1);
        push_any(S_MWB);
      end
      OP_SW: begin
        push_any(S_MADDR);
        for (int i = 0; i < mw; i++) push_step(S_MWR, 1'b0);
        push_step(S_MWR, 1'b1);
      end
      OP_BEQ: push_any(S_BR);
      default: begin push_any(S_JAL); push_any(S_AWB); end
    endcase
    drain(1'b1);
    exp_retired++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'(S_RESET));
    check("rst_ctrl", 32'(ctrl_obs()), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_flags", 32'({illegal, bus_err}), 32'd0);
    exp_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_state", 32'(state_o), 32'(S_RESET));
  endtask

  task automatic check_idle_fetch();
    @(negedge clk);
    mcu_bus.mem_ready = 1'b0;
    #1;
    check("end_state", 32'(state_o), 32'(S_FETCH));
    check("end_retired", retired, 32'(exp_retired));
  endtask

  initial begin
    logic [6:0] ops [6];
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL};
    rst_n = 1'b0;
    opcode = 7'd0;
    mcu_bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 2, 1);
    run_instr(OP_SW, 0, 2);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_I, 0, 0);
    run_instr(OP_JAL, 0, 0);
    for (int k = 0; k < 8; k++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
    check_idle_fetch();

    // illegal opcode trap, held until reset
    do_reset();
    opcode = 7'b0000000;
    push_step(S_FETCH, 1'b1);
    push_any(S_DECODE);
    for (int i = 0; i < 20; i++) push_any(S_TRAP);
    drain(1'b0);
    check("illegal", 32'(illegal), 32'd1);
    check("illegal_buserr", 32'(bus_err), 32'd0);
    do_reset();

    // fetch timeout after 16 stalled request cycles
    opcode = OP_R;
    for (int i = 0; i < 16; i++) push_step(S_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) push_any(S_TRAP);
    drain(1'b0);
    check("bus_err", 32'(bus_err), 32'd1);
    check("bus_err_illegal", 32'(illegal), 32'd0);
    do_reset();

    // ready on the 16th cycle wins over the timeout
    run_instr(OP_R, 15, 0);
    check("no_bus_err", 32'(bus_err), 32'd0);

    // asynchronous reset in the middle of MEM_RD
    opcode = OP_LW;
    push_step(S_FETCH, 1'b1);
    push_any(S_DECODE);
    push_any(S_MADDR);
    push_step(S_MRD, 1'b0);
    push_step(S_MRD, 1'b0);
    drain(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(state_o), 32'(S_RESET));
    check("async_ctrl", 32'(ctrl_obs()), 32'd0);
    check("async_retired", retired, 32'd0);
    exp_retired = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_rel", 32'(state_o), 32'(S_RESET));
    run_instr(OP_R, 0, 0);
    check_idle_fetch();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
